// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter in front of a single-port data memory.
// Requester 0 is the CPU, requester 1 is the DMA/debug port.
// Each accepted command runs IDLE -> ACCESS -> RESP, one transaction per 3 cycles.
// Optional feature:
//   DMEM_ARB_RR_EN - round-robin arbitration on simultaneous requests.
//                    When undefined, r0 always has priority over r1.
// Ports:
//   clk, reset                     - clock, asynchronous active-high reset
//   rN_req/we/addr/wdata/funct3    - command from requester N (held until rN_gnt)
//   rN_gnt                         - one-cycle pulse while the command executes
//   rN_rvalid, rN_rdata            - load result pulse / data (data held until the next load)
//   MemRead, MemWrite, a, wd,
//   Funct3, rd                     - memory command and read data
//   busy                           - high whenever the FSM is not idle
module dmem_arbiter #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [DM_ADDRESS-1:0] r0_addr,
  input  logic [DATA_W-1:0]     r0_wdata,
  input  logic [2:0]            r0_funct3,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_W-1:0]     r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [DM_ADDRESS-1:0] r1_addr,
  input  logic [DATA_W-1:0]     r1_wdata,
  input  logic [2:0]            r1_funct3,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_W-1:0]     r1_rdata,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  output logic [2:0]            Funct3,
  input  logic [DATA_W-1:0]     rd,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  id_q, id_d;  // 0 = r0 owns the in-flight command, 1 = r1
  logic [DATA_W-1:0]     rdata0_q, rdata0_d;
  logic [DATA_W-1:0]     rdata1_q, rdata1_d;
  logic                  winner;

`ifdef DMEM_ARB_RR_EN
  logic last_q, last_d;  // requester granted most recently

  // On a tie the requester not granted last wins; otherwise whoever asks.
  always_comb begin
    winner = (r0_req && r1_req) ? ~last_q : ~r0_req;
  end

  // The pointer moves only when a grant is actually issued.
  always_comb begin
    last_d = last_q;
    if (state_q == StAccess) last_d = id_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b1;  // "r1 last" so r0 wins the first tie
    else       last_q <= last_d;
  end
`else
  always_comb begin
    winner = ~r0_req;
  end
`endif

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    id_d     = id_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      StIdle: begin
        if (r0_req || r1_req) begin
          state_d  = StAccess;
          id_d     = winner;
          we_d     = winner ? r1_we     : r0_we;
          addr_d   = winner ? r1_addr   : r0_addr;
          wdata_d  = winner ? r1_wdata  : r0_wdata;
          funct3_d = winner ? r1_funct3 : r0_funct3;
        end
      end
      StAccess: begin
        state_d = StResp;
        if (!we_q) begin
          if (id_q) rdata1_d = rd;
          else      rdata0_d = rd;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= 3'b000;
      id_q     <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      id_q     <= id_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Outputs decode purely from registered state, so reset clears them at once.
  always_comb begin
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    a         = '0;
    wd        = '0;
    Funct3    = 3'b000;
    r0_gnt    = 1'b0;
    r1_gnt    = 1'b0;
    r0_rvalid = 1'b0;
    r1_rvalid = 1'b0;
    if (state_q == StAccess) begin
      MemRead  = ~we_q;
      MemWrite = we_q;
      a        = addr_q;
      wd       = wdata_q;
      Funct3   = funct3_q;
      r0_gnt   = ~id_q;
      r1_gnt   = id_q;
    end
    if (state_q == StResp && !we_q) begin
      r0_rvalid = ~id_q;
      r1_rvalid = id_q;
    end
  end

  assign busy     = (state_q != StIdle);
  assign r0_rdata = rdata0_q;
  assign r1_rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [8:0]  r0_addr, r1_addr, a;
  logic [31:0] r0_wdata, r1_wdata, wd, rd;
  logic [2:0]  r0_funct3, r1_funct3, Funct3;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic        MemRead, MemWrite, busy;

  int n_checks = 0;
  int n_fails  = 0;
  int n_viol   = 0;
  int seen;

  always #5 clk = ~clk;

  dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_funct3(r0_funct3), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_funct3(r1_funct3), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .Funct3(Funct3),
    .rd(rd), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mutual-exclusion monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if ((r0_gnt && r1_gnt) || (r0_rvalid && r1_rvalid) || (MemRead && MemWrite)) n_viol++;
  end

  initial begin
    int exp_id;
    reset = 1'b1;
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0; r0_funct3 = '0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0; r1_funct3 = '0;
    rd = '0;
    step(); step();
    check("reset_busy", busy, 0);
    check("reset_strobes", {MemRead, MemWrite, r0_gnt, r1_gnt}, 0);
    reset = 1'b0;
    step();

    // r0 LW 0x010, memory returns 0xDEADBEEF
    rd = 32'hDEADBEEF;
    r0_req = 1; r0_we = 0; r0_addr = 9'h010; r0_funct3 = 3'b010;
    step();
    check("lw_gnt", {r0_gnt, r1_gnt}, 2'b10);
    check("lw_memread", {MemRead, MemWrite}, 2'b10);
    check("lw_addr", a, 9'h010);
    check("lw_funct3", Funct3, 3'b010);
    check("lw_rvalid_early", r0_rvalid, 0);
    r0_req = 0;
    step();
    check("lw_rvalid", {r0_rvalid, r1_rvalid}, 2'b10);
    check("lw_rdata", r0_rdata, 32'hDEADBEEF);
    check("lw_resp_strobes", {MemRead, MemWrite, r0_gnt}, 0);
    step();
    check("lw_idle", {busy, r0_rvalid}, 0);
    check("lw_rdata_hold", r0_rdata, 32'hDEADBEEF);

    // r1 SB 0x003 data 0xA5
    r1_req = 1; r1_we = 1; r1_addr = 9'h003; r1_wdata = 32'h0000_00A5; r1_funct3 = 3'b000;
    step();
    check("sb_gnt", {r0_gnt, r1_gnt}, 2'b01);
    check("sb_strobes", {MemRead, MemWrite}, 2'b01);
    check("sb_addr", a, 9'h003);
    check("sb_wd", wd, 32'hA5);
    check("sb_funct3", Funct3, 3'b000);
    r1_req = 0;
    step();
    check("sb_no_rvalid", {r0_rvalid, r1_rvalid, MemWrite}, 0);
    step();

    // Both requesting continuously (undefined funct3 passes through unchanged)
    r0_req = 1; r0_we = 0; r0_addr = 9'h100; r0_funct3 = 3'b111;
    r1_req = 1; r1_we = 0; r1_addr = 9'h1FC; r1_funct3 = 3'b101;
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp_id = i % 2;
`else
      exp_id = 0;
`endif
      rd = 32'h1111_0000 + i;
      step();
      check("both_gnt", {r0_gnt, r1_gnt}, (exp_id == 0) ? 2'b10 : 2'b01);
      check("both_funct3", Funct3, (exp_id == 0) ? 3'b111 : 3'b101);
      step();
      check("both_rvalid", {r0_rvalid, r1_rvalid}, (exp_id == 0) ? 2'b10 : 2'b01);
      check("both_rdata", (exp_id == 0) ? r0_rdata : r1_rdata, 32'h1111_0000 + i);
      step();
    end
    r0_req = 0; r1_req = 0;
    step();
    check("both_done", busy, 0);

    // Reset during ACCESS of an r0 load
    rd = 32'h1234_5678;
    r0_req = 1; r0_we = 0; r0_addr = 9'h020; r0_funct3 = 3'b010;
    step();
    check("rst_pre_gnt", r0_gnt, 1);
    r0_req = 0;
    #3 reset = 1'b1;
    #1;
    check("rst_strobes", {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, MemRead, MemWrite, busy}, 0);
    check("rst_cmd", {a, wd, Funct3}, 0);
    check("rst_rdata", {r0_rdata, r1_rdata}, 0);
    step();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (r0_rvalid || r1_rvalid || busy) seen++;
    end
    check("rst_no_rvalid", seen, 0);
    rd = 32'hCAFE_F00D;
    r0_req = 1; r0_addr = 9'h024;
    step();
    check("rst_next_gnt", {r0_gnt, MemRead, a}, {2'b11, 9'h024});
    r0_req = 0;
    step();
    check("rst_next_rdata", {r0_rvalid, r0_rdata}, {1'b1, 32'hCAFE_F00D});
    step();

    // r1 pulsed for one cycle while r0 is in ACCESS
    rd = 32'h0BAD_0BAD;
    r0_req = 1; r0_addr = 9'h040;
    step();
    check("pulse_r0_gnt", r0_gnt, 1);
    r0_req = 0;
    r1_req = 1; r1_we = 1; r1_addr = 9'h055; r1_wdata = 32'h77;
    step();
    r1_req = 0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (r1_gnt || MemWrite || MemRead) seen++;
      step();
    end
    check("pulse_r1_ignored", seen, 0);
    check("pulse_r0_rdata", r0_rdata, 32'h0BAD_0BAD);

    check("mutex", n_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
